npc_bpred: RTL and testbench

Parametrised next-PC generator for the 5-stage pipeline: holds the fetch PC register and predicts the next fetch address with a direct-mapped branch-target buffer plus 2-bit saturating branch history table. Branch/jump outcomes resolved in EX are fed back to train the tables and, on a misprediction, redirect fetch and request a flush of younger instructions. It replaces the purely combinational next-address select in front of the IF stage.

---
 rtl/npc_bpred.sv | 150 +++++++++++++++
 tb/tb_npc_bpred.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/npc_bpred.sv
// npc_bpred: fetch PC register with next-PC prediction.
// Optional BTB/BHT predictor built when NPC_BPRED_EN is defined; otherwise the
// block always predicts fall-through and relies on EX redirects.
// Resolved branches/jumps from EX train the tables and redirect on mispredict.
module npc_bpred #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_3000,
    parameter int unsigned      BHT_DEPTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    output logic [WIDTH-1:0] pc,
    output logic             pred_taken,
    output logic [WIDTH-1:0] pred_target,
    input  logic             res_valid,
    input  logic             res_cond,
    input  logic [WIDTH-1:0] res_pc,
    input  logic             res_taken,
    input  logic [WIDTH-1:0] res_target,
    input  logic             res_pred_taken,
    input  logic [WIDTH-1:0] res_pred_target,
    output logic             redirect,
    output logic [15:0]      mispredict_cnt
);

    localparam logic [WIDTH-1:0] PC_INC = WIDTH'(4);

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] pc_next;

    assign pc_plus4 = pc + PC_INC;

    // A resolved instruction disagrees with what fetch assumed: wrong direction,
    // or taken to a different address than the one fetched.
    assign redirect = res_valid &&
                      ((res_taken != res_pred_taken) ||
                       (res_taken && (res_target != res_pred_target)));

`ifdef NPC_BPRED_EN
    localparam int unsigned IDX   = $clog2(BHT_DEPTH);
    localparam int unsigned TAG_W = WIDTH - IDX - 2;

    logic             valid_q [BHT_DEPTH];
    logic [TAG_W-1:0] tag_q   [BHT_DEPTH];
    logic [WIDTH-1:0] tgt_q   [BHT_DEPTH];
    logic [1:0]       ctr_q   [BHT_DEPTH];

    logic [IDX-1:0]   lk_idx;
    logic [IDX-1:0]   res_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [TAG_W-1:0] res_tag;
    logic             lk_hit;
    logic             res_hit;
    logic             train_write;
    logic [1:0]       res_ctr_next;

    assign lk_idx  = pc[IDX+1:2];
    assign lk_tag  = pc[WIDTH-1:IDX+2];
    assign res_idx = res_pc[IDX+1:2];
    assign res_tag = res_pc[WIDTH-1:IDX+2];

    // Lookup reads the current array contents, so a same-cycle write is seen
    // only from the next cycle on.
    assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
    assign pred_target = lk_hit ? tgt_q[lk_idx] : pc_plus4;

    assign res_hit     = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
    assign train_write = res_valid && (res_taken || res_hit);

    // Next value of the trained counter: jumps pin to strongly taken, new
    // branch allocations start weakly taken, otherwise saturate up/down.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        res_ctr_next = ctr_q[res_idx];
        if (res_taken) begin
            if (!res_cond) begin
                res_ctr_next = 2'b11;
            end else if (!res_hit) begin
                res_ctr_next = 2'b10;
            end else if (ctr_q[res_idx] != 2'b11) begin
                res_ctr_next = ctr_q[res_idx] + 2'd1;
            end
        end else if (ctr_q[res_idx] != 2'b00) begin
            res_ctr_next = ctr_q[res_idx] - 2'd1;
        end
    end

    // Valid bits and counters: cleared in one cycle by reset, trained from EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (train_write) begin
            valid_q[res_idx] <= 1'b1;
            ctr_q[res_idx]   <= res_ctr_next;
        end
    end

    // Tag/target payload: only meaningful behind a valid bit.
    always_ff @(posedge clk) begin
        // NOTE: payload arrays are not reset; the cleared valid bits already mask stale contents.
        if (!reset && res_valid && res_taken) begin
            tag_q[res_idx] <= res_tag;
            tgt_q[res_idx] <= res_target;
        end
    end
`else
    logic unused_res_cond;

    assign unused_res_cond = res_cond;
    assign pred_taken      = 1'b0;
    assign pred_target     = pc_plus4;
`endif

    // Next-PC select: redirect beats stall, stall beats prediction.
    always_comb begin
        pc_next = pc_plus4;
        if (redirect) begin
            pc_next = res_taken ? res_target : (res_pc + PC_INC);
        end else if (stall) begin
            pc_next = pc;
        end else if (pred_taken) begin
            pc_next = pred_target;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // Saturating count of redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict_cnt <= 16'd0;
        end else if (redirect && (mispredict_cnt != 16'hFFFF)) begin
            mispredict_cnt <= mispredict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_npc_bpred.sv
// Directed testbench for npc_bpred; expectations follow the NPC_BPRED_EN build.
`timescale 1ns/1ps
module tb_npc_bpred;

`ifdef NPC_BPRED_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic        res_cond;
    logic [31:0] res_pc;
    logic        res_taken;
    logic [31:0] res_target;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic        redirect;
    logic [15:0] mispredict_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    npc_bpred #(.WIDTH(32), .RESET_PC(32'h0000_3000), .BHT_DEPTH(64)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc(pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_cond(res_cond), .res_pc(res_pc),
        .res_taken(res_taken), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .redirect(redirect), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        res_valid = 1'b0; res_cond = 1'b0; res_pc = '0; res_taken = 1'b0;
        res_target = '0; res_pred_taken = 1'b0; res_pred_target = '0;
    endtask

    task automatic resolve(input logic cond, input logic [31:0] rpc, input logic taken,
                           input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
        res_valid = 1'b1; res_cond = cond; res_pc = rpc; res_taken = taken;
        res_target = tgt; res_pred_taken = ptaken; res_pred_target = ptgt;
    endtask

    // Force fetch to addr via a mispredicted not-taken branch at addr-4.
    task automatic jump_to(input logic [31:0] addr);
        resolve(1'b1, addr - 32'd4, 1'b0, addr, 1'b1, addr);
        tick();
        idle();
        exp_cnt++;
        n_checks++;
        if (pc !== addr) begin n_errors++; $display("FAIL jump_to_pc: got %h expected %h", pc, addr); end
        #1;
    endtask

    task automatic check_cnt(input string name);
        n_checks++;
        if (mispredict_cnt !== 16'(exp_cnt)) begin
            n_errors++; $display("FAIL %s_cnt: got %0d expected %0d", name, mispredict_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; idle();
        tick(); tick();
        reset = 1'b0;
        #1;
        n_checks++; if (pc !== 32'h3000) begin n_errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h3000); end
        n_checks++; if (pred_taken !== 1'b0) begin n_errors++; $display("FAIL reset_pred_taken: got %b expected 0", pred_taken); end
        n_checks++; if (pred_target !== 32'h3004) begin n_errors++; $display("FAIL reset_pred_target: got %h expected %h", pred_target, 32'h3004); end
        n_checks++; if (redirect !== 1'b0) begin n_errors++; $display("FAIL reset_redirect: got %b expected 0", redirect); end
        check_cnt("reset");
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_pc = 32'h3000 + 32'(4 * i);
            n_checks++; if (pc !== exp_pc) begin n_errors++; $display("FAIL seq_pc%0d: got %h expected %h", i, pc, exp_pc); end
            n_checks++; if (pred_taken !== 1'b0) begin n_errors++; $display("FAIL seq_pred%0d: got %b expected 0", i, pred_taken); end
        end
        tick();
        n_checks++; if (pc !== 32'h3010) begin n_errors++; $display("FAIL seq_pc4: got %h expected %h", pc, 32'h3010); end
    endtask

    task automatic test_taken_branch();
        resolve(1'b1, 32'h3010, 1'b1, 32'h3040, 1'b0, 32'h3014);
        #1;
        n_checks++; if (redirect !== 1'b1) begin n_errors++; $display("FAIL beq_redirect: got %b expected 1", redirect); end
        tick(); idle(); exp_cnt++;
        n_checks++; if (pc !== 32'h3040) begin n_errors++; $display("FAIL beq_pc: got %h expected %h", pc, 32'h3040); end
        check_cnt("beq");
        jump_to(32'h3010);
        n_checks++; if (pred_taken !== BP_EN) begin n_errors++; $display("FAIL beq_refetch_pred: got %b expected %b", pred_taken, BP_EN); end
        n_checks++;
        if (pred_target !== (BP_EN ? 32'h3040 : 32'h3014)) begin
            n_errors++; $display("FAIL beq_refetch_target: got %h expected %h", pred_target, BP_EN ? 32'h3040 : 32'h3014);
        end
    endtask

    task automatic test_loop_exit();
        // Train counter 10 -> 11 with a correctly predicted taken resolve.
        resolve(1'b1, 32'h3010, 1'b1, 32'h3040, BP_EN, BP_EN ? 32'h3040 : 32'h3014);
        #1;
        n_checks++; if (redirect !== !BP_EN) begin n_errors++; $display("FAIL loop_train_redirect: got %b expected %b", redirect, !BP_EN); end
        tick(); idle();
        if (!BP_EN) exp_cnt++;
        n_checks++; if (pc !== 32'h3040) begin n_errors++; $display("FAIL loop_train_pc: got %h expected %h", pc, 32'h3040); end
        // Loop exit: not taken while predicted taken.
        resolve(1'b1, 32'h3010, 1'b0, 32'h3040, 1'b1, 32'h3040);
        #1;
        n_checks++; if (redirect !== 1'b1) begin n_errors++; $display("FAIL loop_exit_redirect: got %b expected 1", redirect); end
        tick(); idle(); exp_cnt++;
        n_checks++; if (pc !== 32'h3014) begin n_errors++; $display("FAIL loop_exit_pc: got %h expected %h", pc, 32'h3014); end
        jump_to(32'h3010);
        n_checks++; if (pred_taken !== BP_EN) begin n_errors++; $display("FAIL loop_weak_pred: got %b expected %b", pred_taken, BP_EN); end
        // Second not-taken at the fetched index: lookup still shows old counter.
        resolve(1'b1, 32'h3010, 1'b0, 32'h3040, 1'b1, 32'h3040);
        #1;
        n_checks++; if (pred_taken !== BP_EN) begin n_errors++; $display("FAIL loop_rbw_pred: got %b expected %b", pred_taken, BP_EN); end
        tick(); idle(); exp_cnt++;
        n_checks++; if (pc !== 32'h3014) begin n_errors++; $display("FAIL loop_exit2_pc: got %h expected %h", pc, 32'h3014); end
        jump_to(32'h3010);
        n_checks++; if (pred_taken !== 1'b0) begin n_errors++; $display("FAIL loop_nt_pred: got %b expected 0", pred_taken); end
        check_cnt("loop");
    endtask

    task automatic test_stall();
        stall = 1'b1;
        tick();
        n_checks++; if (pc !== 32'h3010) begin n_errors++; $display("FAIL stall_hold_pc: got %h expected %h", pc, 32'h3010); end
        resolve(1'b1, 32'h3050, 1'b1, 32'h3080, 1'b0, 32'h3054);
        #1;
        n_checks++; if (redirect !== 1'b1) begin n_errors++; $display("FAIL stall_redirect: got %b expected 1", redirect); end
        tick(); idle(); exp_cnt++;
        n_checks++; if (pc !== 32'h3080) begin n_errors++; $display("FAIL stall_redirect_pc: got %h expected %h", pc, 32'h3080); end
        stall = 1'b0;
        tick();
        n_checks++; if (pc !== 32'h3084) begin n_errors++; $display("FAIL stall_release_pc: got %h expected %h", pc, 32'h3084); end
        check_cnt("stall");
    endtask

    task automatic test_jalr();
        resolve(1'b0, 32'h3020, 1'b1, 32'h3100, 1'b0, 32'h3024);
        tick(); idle(); exp_cnt++;
        n_checks++; if (pc !== 32'h3100) begin n_errors++; $display("FAIL jalr1_pc: got %h expected %h", pc, 32'h3100); end
        resolve(1'b0, 32'h3020, 1'b1, 32'h3200, BP_EN, BP_EN ? 32'h3100 : 32'h3024);
        #1;
        n_checks++; if (redirect !== 1'b1) begin n_errors++; $display("FAIL jalr2_redirect: got %b expected 1", redirect); end
        tick(); idle(); exp_cnt++;
        n_checks++; if (pc !== 32'h3200) begin n_errors++; $display("FAIL jalr2_pc: got %h expected %h", pc, 32'h3200); end
        jump_to(32'h3020);
        n_checks++; if (pred_taken !== BP_EN) begin n_errors++; $display("FAIL jalr_pred: got %b expected %b", pred_taken, BP_EN); end
        n_checks++;
        if (pred_target !== (BP_EN ? 32'h3200 : 32'h3024)) begin
            n_errors++; $display("FAIL jalr_target: got %h expected %h", pred_target, BP_EN ? 32'h3200 : 32'h3024);
        end
        check_cnt("jalr");
    endtask

    task automatic test_wrap();
        resolve(1'b1, 32'h3024, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h3028);
        tick(); idle(); exp_cnt++;
        n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_pc: got %h expected %h", pc, 32'hFFFF_FFFC); end
        n_checks++; if (pred_target !== 32'h0) begin n_errors++; $display("FAIL wrap_target: got %h expected 0", pred_target); end
        tick();
        n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL wrap_next_pc: got %h expected 0", pc); end
    endtask

    task automatic test_reset_mid();
        stall = 1'b1; reset = 1'b1;
        resolve(1'b1, 32'h3060, 1'b1, 32'h3090, 1'b0, 32'h3064);
        tick();
        reset = 1'b0; stall = 1'b0; idle(); exp_cnt = 0;
        #1;
        n_checks++; if (pc !== 32'h3000) begin n_errors++; $display("FAIL rstmid_pc: got %h expected %h", pc, 32'h3000); end
        check_cnt("rstmid");
        jump_to(32'h3020);
        n_checks++; if (pred_taken !== 1'b0) begin n_errors++; $display("FAIL rstmid_pred: got %b expected 0", pred_taken); end
        n_checks++; if (pred_target !== 32'h3024) begin n_errors++; $display("FAIL rstmid_target: got %h expected %h", pred_target, 32'h3024); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            resolve(1'b1, 32'h3010, 1'b1, 32'h3040, 1'b0, 32'h3014);
            #1;
            n_checks++; if (redirect !== 1'b1) begin n_errors++; $display("FAIL b2b_redirect%0d: got %b expected 1", i, redirect); end
            tick(); exp_cnt++;
            n_checks++; if (pc !== 32'h3040) begin n_errors++; $display("FAIL b2b_pc%0d: got %h expected %h", i, pc, 32'h3040); end
            n_checks++; if (pred_taken !== 1'b0) begin n_errors++; $display("FAIL b2b_pred%0d: got %b expected 0", i, pred_taken); end
        end
        idle();
        check_cnt("b2b");
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_taken_branch();
        test_loop_exit();
        test_stall();
        test_jalr();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
